programmable_square_wave_oscillator: RTL and testbench
======================================================

# programmable_square_wave_oscillator

Gated, runtime-programmable astable square-wave generator for discrete-audio models. It produces a square wave whose high and low phase lengths, and therefore frequency and duty cycle, are set per phase in clock cycles. An enable input behaves like a 555 reset pin: it holds the output low and restarts the wave with a full high phase. It sits between parent modules that compute cycle counts from R/C values and the audio mixers, and presents a sample-rate-held output.

## Interface
- CLOCK_RATE, 50000000, system clock frequency in Hz; informational, used by parents to derive cycle counts.
- COUNT_WIDTH, 24, width of the phase-length inputs and the internal counter.
- OUT_WIDTH, 16, width of `out`.
- AMPLITUDE, all ones at OUT_WIDTH, value driven on `out` during the high phase (unsigned).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset; priority over all other inputs.
- audio_clk_en  input  1  one-cycle sample strobe; `out` updates only on these cycles.
- enable  input  1  1 = oscillate, 0 = hold idle (phase low).
- high_cycles  input  COUNT_WIDTH  high-phase length in clk cycles; 0 is treated as 1.
- low_cycles  input  COUNT_WIDTH  low-phase length in clk cycles; 0 is treated as 1.
- out  output  OUT_WIDTH  sampled waveform, either AMPLITUDE or 0.
- phase  output  1  registered raw waveform at clk resolution.
- edge_strobe  output  1  one-cycle pulse on every change of `phase`.

## Operation
- Three states: IDLE, HIGH, LOW. Internal registers: a COUNT_WIDTH counter `cnt` and a COUNT_WIDTH latched length `len`.
- Reset: state IDLE, cnt 0, len 0, phase 0, edge_strobe 0, out 0.
- Clamping: len = (input == 0) ? 1 : input. The maximum phase length is 2^COUNT_WIDTH − 1. No other arithmetic is applied; the counter never exceeds len − 1.
- IDLE: phase 0. If enable = 1, go to HIGH, latch len from high_cycles, set cnt 0, and pulse edge_strobe.
- HIGH, enable = 1:
  - If cnt == len − 1: go to LOW, latch len from low_cycles, set cnt 0, pulse edge_strobe.
  - Otherwise: cnt + 1.
- LOW, enable = 1:
  - If cnt == len − 1: go to HIGH, latch len from high_cycles, set cnt 0, pulse edge_strobe.
  - Otherwise: cnt + 1.
- Period is exactly len_high + len_low cycles, with duty = len_high / period.
- high_cycles and low_cycles are sampled only at the phase-entry edge. Changing them mid-phase affects only the next phase of that kind, so there are no glitches or truncated phases.
- HIGH or LOW with enable = 0: go to IDLE, set cnt 0, phase 0.
  - edge_strobe pulses only if leaving HIGH, i.e. only when phase actually changes.
- Re-enable from IDLE always starts a fresh, full-length high phase.
- phase = 1 exactly in state HIGH, and is registered with the state.
- out: on a cycle with audio_clk_en = 1, out <= phase ? AMPLITUDE : 0, using the phase register value before that edge. Otherwise out holds.

## Timing
- enable rising is sampled at edge N; phase = 1 and edge_strobe = 1 after edge N; edge_strobe = 0 after edge N+1.
- Latency enable→phase is 1 clk. Latency phase→out is 1 clk after the next audio_clk_en.
- enable falling is sampled at edge N; phase = 0 after edge N.
- Simultaneous enable = 0 and terminal count: enable wins, go to IDLE (not LOW→…).
- reset during any state: all registers take their reset values at that edge, including out, regardless of audio_clk_en.
- reset and enable both 1: reset wins; HIGH is entered on the first edge after reset deasserts, if enable is still 1.
- With len = 1 in both phases, phase toggles every cycle and edge_strobe is held high continuously.

## Test plan
- Reset check: assert reset 2 cycles with enable = 1 → phase 0, edge_strobe 0, out 0, state IDLE; first HIGH one edge after release.
- Basic wave: high_cycles = 3, low_cycles = 5, enable = 1 → phase 1,1,1,0,0,0,0,0 repeating, period 8; edge_strobe on cycles 0, 3, 8, 11.
- Mid-phase reprogram: during HIGH (cnt = 1) change high_cycles 3→6 → current high stays 3; next high is 6 cycles. The same holds for low_cycles.
- Zero and extremes: high_cycles = 0, low_cycles = 0 → phase toggles every cycle and edge_strobe is constant 1. high_cycles = 2^24 − 1 → counter reaches 0xFFFFFE with no wrap before LOW.
- Gating: drop enable at LOW cnt = 2 → IDLE with no strobe. Drop it at HIGH cnt = 1 → phase 0 next edge with a strobe. Re-enable → full 3-cycle high.
- Sampling: audio_clk_en every 4 cycles, AMPLITUDE = 16'h7FFF, 3/5 wave → out changes only on strobe cycles, takes values 0x7FFF or 0, and matches phase delayed one clk. Mid-run reset → out 0 immediately.

Source files
------------

// File: rtl/programmable_square_wave_oscillator.sv
// Gated astable square-wave generator.
// The high and low phase lengths are programmable in clk cycles.
// A per-phase length is latched on entry to that phase.
// The waveform is presented at clk resolution on `phase` and sample-held on `out`.
module programmable_square_wave_oscillator #(
  parameter int unsigned            CLOCK_RATE  = 50000000,
  parameter int unsigned            COUNT_WIDTH = 24,
  parameter int unsigned            OUT_WIDTH   = 16,
  parameter logic [OUT_WIDTH-1:0]   AMPLITUDE   = {OUT_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   audio_clk_en,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] high_cycles,
  input  logic [COUNT_WIDTH-1:0] low_cycles,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   phase,
  output logic                   edge_strobe
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // A zero clock rate means the parent derived its cycle counts from nonsense
  if (CLOCK_RATE == 0) begin : g_bad_clock_rate
    $error("programmable_square_wave_oscillator: CLOCK_RATE must be nonzero");
  end

  logic [1:0]             state, state_d;
  logic [COUNT_WIDTH-1:0] cnt, cnt_d;
  logic [COUNT_WIDTH-1:0] len, len_d;
  logic [OUT_WIDTH-1:0]   out_d;
  logic                   phase_d;
  logic                   strobe_d;

  // A programmed length of zero behaves as a one-cycle phase
  function automatic logic [COUNT_WIDTH-1:0] clamp_len(input logic [COUNT_WIDTH-1:0] v);
    return (v == '0) ? COUNT_WIDTH'(1) : v;
  endfunction

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      len         <= '0;
      phase       <= 1'b0;
      edge_strobe <= 1'b0;
      out         <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      len         <= len_d;
      phase       <= phase_d;
      edge_strobe <= strobe_d;
      out         <= out_d;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    len_d    = len;
    out_d    = audio_clk_en ? (phase ? AMPLITUDE : '0) : out;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_HIGH;
          len_d   = clamp_len(high_cycles);
          cnt_d   = '0;
        end
      end
      ST_HIGH: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == len - COUNT_WIDTH'(1)) begin
          state_d = ST_LOW;
          len_d   = clamp_len(low_cycles);
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt + COUNT_WIDTH'(1);
        end
      end
      ST_LOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == len - COUNT_WIDTH'(1)) begin
          state_d = ST_HIGH;
          len_d   = clamp_len(high_cycles);
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The strobe marks every level change, so leaving LOW for IDLE is silent
    phase_d  = (state_d == ST_HIGH);
    strobe_d = (phase_d != phase);
  end

endmodule

// File: tb/tb_programmable_square_wave_oscillator.sv
// Scoreboard bench for programmable_square_wave_oscillator.
// The reference model tracks the waveform as a level plus the cycles left in the current phase.
module tb_programmable_square_wave_oscillator;

  localparam int unsigned CW  = 10;
  localparam int unsigned OW  = 16;
  localparam logic [OW-1:0] AMP = 16'h7FFF;
  localparam int MAXLEN = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          audio_clk_en = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] high_cycles = '0;
  logic [CW-1:0] low_cycles = '0;
  logic [OW-1:0] out;
  logic          phase;
  logic          edge_strobe;

  programmable_square_wave_oscillator #(
    .CLOCK_RATE(50000000), .COUNT_WIDTH(CW), .OUT_WIDTH(OW), .AMPLITUDE(AMP)
  ) dut (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .enable(enable),
    .high_cycles(high_cycles), .low_cycles(low_cycles),
    .out(out), .phase(phase), .edge_strobe(edge_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ph;
    logic        st;
    logic [OW-1:0] o;
  } exp_t;

  exp_t q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;
  bit   active = 0;
  int   cyc = 0;

  // Reference state: current level, idle flag, cycles remaining after the current one
  logic          m_level = 0;
  bit            m_idle  = 1;
  int            m_rem   = 0;
  logic [OW-1:0] m_out   = '0;

  function automatic int eff_len(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Apply one cycle of inputs and queue what the outputs must be after the edge
  task automatic step(input bit rst, input bit en, input int hi, input int lo, input bit aen);
    exp_t e;
    logic old;
    @(negedge clk);
    reset = rst; enable = en; audio_clk_en = aen;
    high_cycles = CW'(hi); low_cycles = CW'(lo);
    old = m_level;
    if (rst) begin
      m_level = 0; m_idle = 1; m_rem = 0; m_out = '0;
      e.st = 0;
    end else begin
      if (aen) m_out = old ? AMP : '0;
      if (!en) begin
        m_level = 0; m_idle = 1;
      end else if (m_idle) begin
        m_idle = 0; m_level = 1; m_rem = eff_len(hi) - 1;
      end else if (m_rem == 0) begin
        m_level = ~m_level;
        m_rem = eff_len(m_level ? hi : lo) - 1;
      end else begin
        m_rem = m_rem - 1;
      end
      e.st = (m_level != old);
    end
    e.ph = m_level; e.o = m_out; e.cyc = cyc;
    q.push_back(e);
    cyc++;
    active = 1;
  endtask

  // Monitor: every clock edge presents a fresh output triple to check
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        n_compared++;
        if (q.size() == 0) begin
          n_mismatch++;
          $display("FAIL scoreboard_empty: output seen with no expectation queued");
        end else begin
          e = q.pop_front();
          if (phase !== e.ph || edge_strobe !== e.st || out !== e.o) begin
            n_mismatch++;
            $display("FAIL cycle %0d phase/strobe/out: got %b/%b/%h want %b/%b/%h",
                     e.cyc, phase, edge_strobe, out, e.ph, e.st, e.o);
          end
        end
      end
    end
  end

  initial begin
    bit en;
    int hi, lo;
    // Reset held two cycles with enable high, then the basic 3/5 wave sampled every 4 cycles
    step(1, 1, 3, 5, 1);
    step(1, 1, 3, 5, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 3, 5, (i % 4) == 3);
    // Mid-phase reprogramming: only the next phase of each kind changes
    for (int i = 0; i < 40; i++) step(0, 1, (i < 10) ? 3 : 6, (i < 20) ? 5 : 2, (i % 4) == 0);
    // Gating: drops in both phases, then re-enable
    for (int i = 0; i < 12; i++) step(0, 1, 3, 5, 0);
    step(0, 0, 3, 5, 1);
    step(0, 0, 3, 5, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 3, 5, 0);
    step(0, 0, 3, 5, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 3, 5, 1);
    // Zero lengths clamp to one cycle: toggle every cycle, strobe held high
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1);
    // Longest high phase, no wrap before LOW
    step(0, 0, MAXLEN, 2, 0);
    for (int i = 0; i < 2 * MAXLEN + 20; i++) step(0, 1, MAXLEN, 2, (i % 97) == 0);
    // Mid-run reset clears out even without a sample strobe
    for (int i = 0; i < 6; i++) step(0, 1, 3, 5, 1);
    step(1, 1, 3, 5, 0);
    step(0, 1, 3, 5, 0);
    // Randomized traffic
    en = 1; hi = 3; lo = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 9) == 0) hi = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(0, 6);
      step($urandom_range(0, 99) == 0, en, hi, lo, $urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    #2;
    active = 0;
    n_compared++;
    if (q.size() != 0) begin
      n_mismatch++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
